// File: rtl/logic_unit_pkg.sv
// Shared types and helpers for the shared bitwise logic unit arbiter.
package logic_unit_pkg;

  localparam logic [1:0] OP_AND  = 2'b00;
  localparam logic [1:0] OP_OR   = 2'b01;
  localparam logic [1:0] OP_XOR  = 2'b10;
  localparam logic [1:0] OP_NAND = 2'b11;

  typedef enum logic {ST_EMPTY = 1'b0, ST_FULL = 1'b1} out_state_e;

  function automatic int id_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Single-bit slice of the logic unit; callers iterate over the data width.
  function automatic logic logic_op(input logic a, input logic b, input logic [1:0] op);
    case (op)
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_XOR:  return a ^ b;
      default: return ~(a & b);
    endcase
  endfunction

endpackage

// File: rtl/logic_unit_arbiter_if.sv
// Request/response bundle between requesters, the arbiter and the result consumer.
interface logic_unit_arbiter_if
  import logic_unit_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 8,
    parameter int CNT_W   = 16
);
    localparam int ID_W = id_w(NUM_REQ);

    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ*DATA_W-1:0] req_a;
    logic [NUM_REQ*DATA_W-1:0] req_b;
    logic [NUM_REQ*2-1:0]      req_op;
    logic                      rsp_valid;
    logic                      rsp_ready;
    logic [DATA_W-1:0]         rsp_data;
    logic [ID_W-1:0]           rsp_id;
    logic [CNT_W-1:0]          op_count;

    modport master (
        output req_valid, req_a, req_b, req_op, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_id, op_count
    );

    modport slave (
        input  req_valid, req_a, req_b, req_op, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_id, op_count
    );
endinterface

// File: rtl/logic_unit_arbiter_rr_grant.sv
// Combinational round-robin arbiter: rotate requests by ptr, pick lowest, rotate back.
module rr_grant
  import logic_unit_pkg::*;
#(
    parameter int N  = 4,
    parameter int PW = id_w(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [PW-1:0] ptr_i,
    output logic [N-1:0]  grant_o,
    output logic [PW-1:0] idx_o,
    output logic          any_o
);
    logic [2*N-1:0] dbl, rot;
    logic [PW:0]    sel, sum;

    always_comb begin
        dbl   = {req_i, req_i};
        rot   = dbl >> ptr_i;
        sel   = '0;
        any_o = 1'b0;
        // Descending scan so the lowest rotated position wins.
        for (int i = N - 1; i >= 0; i--) begin
            if (rot[i]) begin
                sel   = (PW+1)'(i);
                any_o = 1'b1;
            end
        end
        sum = sel + {1'b0, ptr_i};
        if (sum >= (PW+1)'(N)) sum = sum - (PW+1)'(N);
        idx_o   = sum[PW-1:0];
        grant_o = '0;
        if (any_o) grant_o[idx_o] = 1'b1;
    end
endmodule

// File: rtl/logic_unit_arbiter.sv
// One shared AND/OR/XOR/NAND unit, round-robin arbitrated, with a single-entry result stage.
module logic_unit_arbiter
  import logic_unit_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 8,
    parameter int CNT_W   = 16
) (
    input logic                 clk,
    input logic                 rst_n,
    logic_unit_arbiter_if.slave bus
);
    localparam int ID_W = id_w(NUM_REQ);

    out_state_e                     state_q, state_d;
    logic [ID_W-1:0]                rr_ptr_q, rr_ptr_d;
    logic [DATA_W-1:0]              data_q;
    logic [ID_W-1:0]                id_q;
    logic [CNT_W-1:0]               cnt_q;
    logic [NUM_REQ-1:0]             gnt;
    logic [ID_W-1:0]                gnt_idx;
    logic                           gnt_any;
    logic                           rsp_valid, accept_en, accept;
    logic [NUM_REQ-1:0][DATA_W-1:0] lane_res;

    rr_grant #(.N(NUM_REQ), .PW(ID_W)) u_grant (
        .req_i   (bus.req_valid),
        .ptr_i   (rr_ptr_q),
        .grant_o (gnt),
        .idx_o   (gnt_idx),
        .any_o   (gnt_any)
    );

    // Every lane evaluates its own op; the granted lane is muxed into the register.
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            for (int j = 0; j < DATA_W; j++) begin
                lane_res[i][j] = logic_op(bus.req_a[i*DATA_W+j], bus.req_b[i*DATA_W+j],
                                          bus.req_op[i*2 +: 2]);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_EMPTY;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_EMPTY: if (accept) state_d = ST_FULL;
            ST_FULL:  if (bus.rsp_ready && !accept) state_d = ST_EMPTY;
            default:  state_d = ST_EMPTY;
        endcase
    end

    // Reset gates accept so no requester sees ready while held in reset.
    always_comb begin
        rsp_valid = (state_q == ST_FULL);
        accept_en = rst_n & (~rsp_valid | bus.rsp_ready);
        accept    = accept_en & gnt_any;
    end

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (accept) rr_ptr_d = (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q <= '0;
            data_q   <= '0;
            id_q     <= '0;
            cnt_q    <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
            if (accept) begin
                data_q <= lane_res[gnt_idx];
                id_q   <= gnt_idx;
            end
            if (rsp_valid && bus.rsp_ready && (cnt_q != '1)) cnt_q <= cnt_q + 1'b1;
        end
    end

    assign bus.req_ready = gnt & {NUM_REQ{accept_en}};
    assign bus.rsp_valid = rsp_valid;
    assign bus.rsp_data  = data_q;
    assign bus.rsp_id    = id_q;
    assign bus.op_count  = cnt_q;
endmodule
